// File: rtl/ram_req_sequencer.sv
// Request sequencer for the asynchronous cellular-RAM interface: power-up wait, one access at a time, CS-low gap.
// Optional macro RAM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES without a qualified ready.
module ram_req_sequencer #(
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 16,
    parameter int PWRUP_CYCLES   = 16000,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_rnw_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              init_done_o,
    output logic              ram_cs_o,
    output logic              ram_rnw_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ready_i
);

    localparam int INIT_W = ($clog2(PWRUP_CYCLES + 1) < 1) ? 1 : $clog2(PWRUP_CYCLES + 1);
    localparam int ACC_W  = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [INIT_W-1:0]   init_cnt_r, init_cnt_s;
    logic [ACC_W-1:0]    acc_cnt_r, acc_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
    logic                req_ready_r, req_ready_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic                rsp_err_r, rsp_err_s;
    logic                init_done_r, init_done_s;
    logic                cs_r, cs_s;
    logic                rnw_r, rnw_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                ready_qual_s;

    // Ready may still be high from the previous access, so the first ACCESS cycle never counts.
    assign ready_qual_s = (acc_cnt_r != {ACC_W{1'b0}}) && ram_ready_i;

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        init_cnt_s  = init_cnt_r;
        acc_cnt_s   = acc_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        req_ready_s = req_ready_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = 1'b0;
        init_done_s = init_done_r;
        cs_s        = cs_r;
        rnw_s       = rnw_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;

        case (state_r)
            ST_INIT: begin
                if ((int'(init_cnt_r) + 32'sd1) >= PWRUP_CYCLES) begin
                    state_s     = ST_IDLE;
                    init_done_s = 1'b1;
                    req_ready_s = 1'b1;
                end else begin
                    init_cnt_s = init_cnt_r + INIT_W'(1'b1);
                end
            end
            ST_IDLE: begin
                if (req_valid_i && req_ready_r) begin
                    rnw_s       = req_rnw_i;
                    addr_s      = req_addr_i;
                    wdata_s     = req_wdata_i;
                    cs_s        = 1'b1;
                    req_ready_s = 1'b0;
                    acc_cnt_s   = {ACC_W{1'b0}};
                    state_s     = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (acc_cnt_r != {ACC_W{1'b1}}) begin
                    acc_cnt_s = acc_cnt_r + ACC_W'(1'b1);
                end else begin
                    acc_cnt_s = acc_cnt_r;
                end
                if (ready_qual_s) begin
                    cs_s        = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = rnw_r ? ram_rdata_i : {DATA_W{1'b0}};
                    gap_cnt_s   = {GAP_W{1'b0}};
                    state_s     = ST_GAP;
`ifdef RAM_TIMEOUT_EN
                end else if ((int'(acc_cnt_r) + 32'sd1) >= TIMEOUT_CYCLES) begin
                    cs_s        = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = {DATA_W{1'b0}};
                    gap_cnt_s   = {GAP_W{1'b0}};
                    state_s     = ST_GAP;
`endif
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_GAP: begin
                if ((int'(gap_cnt_r) + 32'sd1) >= GAP_CYCLES) begin
                    state_s     = ST_IDLE;
                    req_ready_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1'b1);
                end
            end
            default: begin
                state_s     = ST_INIT;
                init_cnt_s  = {INIT_W{1'b0}};
                init_done_s = 1'b0;
                req_ready_s = 1'b0;
                cs_s        = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= {INIT_W{1'b0}};
            acc_cnt_r   <= {ACC_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            init_done_r <= 1'b0;
            cs_r        <= 1'b0;
            rnw_r       <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            init_cnt_r  <= init_cnt_s;
            acc_cnt_r   <= acc_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            init_done_r <= init_done_s;
            cs_r        <= cs_s;
            rnw_r       <= rnw_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign init_done_o = init_done_r;
    assign ram_cs_o    = cs_r;
    assign ram_rnw_o   = rnw_r;
    assign ram_addr_o  = addr_r;
    assign ram_wdata_o = wdata_r;

endmodule

// File: tb/tb_ram_req_sequencer.sv
// Self-checking bench for ram_req_sequencer: vector table plus scoreboard, with a RAM stub of programmable latency.
module tb_ram_req_sequencer;

    localparam int AW   = 26;
    localparam int DW   = 16;
    localparam int PWR  = 20;
    localparam int GAP  = 2;
    localparam int TMO  = 64;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_rnw_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          init_done_o;
    logic          ram_cs_o;
    logic          ram_rnw_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;
    logic          ram_ready_i;

    ram_req_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .PWRUP_CYCLES(PWR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rnw_i(req_rnw_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .init_done_o(init_done_o),
        .ram_cs_o(ram_cs_o), .ram_rnw_o(ram_rnw_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ready_i(ram_ready_i)
    );

    always #5 clk = ~clk;

    // RAM stub: ready after stub_lat cs-high cycles (0 = never); stale mode keeps ready high outside accesses.
    int          stub_lat   = 0;
    logic        stub_stale = 1'b0;
    logic [DW-1:0] stub_rdata = '0;
    int          acc_i = 0;

    always @(posedge clk) begin
        if (ram_cs_o) acc_i <= acc_i + 1;
        else          acc_i <= 0;
    end

    assign ram_ready_i = (ram_cs_o && stub_lat != 0 && acc_i >= stub_lat - 1) ||
                         (stub_stale && (!ram_cs_o || acc_i == 0));
    assign ram_rdata_i = stub_rdata ^ ram_addr_o[15:0];

    typedef struct {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } sb_t;

    typedef struct {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic          stale;
        logic [DW-1:0] stub;
        logic [DW-1:0] exp_rdata;
        int            exp_len;
    } vec_t;

    sb_t  q[$];
    sb_t  cur;
    int   total = 0;
    int   bad   = 0;
    int   rsp_cnt = 0;
    int   n_accept = 0;
    int   hi_len = 0;
    int   lo_len = 100;
    int   cs_len_last = 0;
    logic cs_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on responses, stability of RAM-side signals, CS-low spacing.
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            rsp_cnt++;
            check("rsp_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                sb_t e;
                e = q.pop_front();
                check("rsp_rdata", 32'(rsp_rdata_o), 32'(e.exp_rdata));
                check("rsp_err", 32'(rsp_err_o), 32'(e.exp_err));
            end
        end
        if (ram_cs_o && !cs_prev) begin
            check("cs_after_init", 32'(init_done_o), 32'd1);
            check("cs_low_gap", 32'(lo_len >= GAP + 1), 32'd1);
            check("accept_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) cur = q[0];
        end
        if (ram_cs_o) begin
            check("ram_addr_hold", 32'(ram_addr_o), 32'(cur.addr));
            check("ram_wdata_hold", 32'(ram_wdata_o), 32'(cur.wdata));
            check("ram_rnw_hold", 32'(ram_rnw_o), 32'(cur.rnw));
            hi_len++;
            lo_len = 0;
        end else begin
            if (cs_prev) cs_len_last = hi_len;
            hi_len = 0;
            lo_len++;
        end
        cs_prev = ram_cs_o;
    end

    task automatic send(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] er, input logic ee, input logic hold);
        int n;
        sb_t e;
        req_rnw_i   = rnw;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(req_ready_o), 32'd1);
        if (req_ready_o) begin
            e.rnw = rnw; e.addr = a; e.wdata = wd; e.exp_rdata = er; e.exp_err = ee;
            q.push_back(e);
            n_accept++;
        end
        @(negedge clk);
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rsp_in_time", 32'(q.size()), 32'd0);
    endtask

    // Called at the negedge right after the last reset-high edge.
    task automatic powerup_check();
        for (int k = 1; k <= PWR; k++) begin
            @(negedge clk);
            check("init_cs_low", 32'(ram_cs_o), 32'd0);
            if (k < PWR) begin
                check("init_done_early", 32'(init_done_o), 32'd0);
                check("ready_early", 32'(req_ready_o), 32'd0);
            end else begin
                check("init_done_rise", 32'(init_done_o), 32'd1);
                check("ready_rise", 32'(req_ready_o), 32'd1);
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 26'h0000123, 16'hBEEF, 8, 1'b0, 16'h1111, 16'h0000, 8};
        vecs[1] = '{1'b1, 26'h3FFFFFF, 16'h0000, 2, 1'b0, 16'h5A5A, 16'hA5A5, 2};
        vecs[2] = '{1'b1, 26'h1000000, 16'h1234, 4, 1'b1, 16'hA5C3, 16'hA5C3, 4};
        vecs[3] = '{1'b1, 26'h0000F0F, 16'h0000, 1, 1'b1, 16'h0001, 16'h0F0E, 2};
        vecs[4] = '{1'b0, 26'h2AAAAAA, 16'h5555, 3, 1'b1, 16'hFFFF, 16'h0000, 3};
        vecs[5] = '{1'b1, 26'h0000000, 16'h0000, 5, 1'b0, 16'hFFFF, 16'hFFFF, 5};

        reset_i     = 1'b1;
        req_valid_i = 1'b1;
        req_rnw_i   = vecs[0].rnw;
        req_addr_i  = vecs[0].addr;
        req_wdata_i = vecs[0].wdata;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        check("rst_cs", 32'(ram_cs_o), 32'd0);
        check("rst_rnw", 32'(ram_rnw_o), 32'd0);
        check("rst_addr", 32'(ram_addr_o), 32'd0);
        check("rst_wdata", 32'(ram_wdata_o), 32'd0);
        reset_i = 1'b0;
        powerup_check();

        for (int i = 0; i < 6; i++) begin
            stub_lat   = vecs[i].lat;
            stub_stale = vecs[i].stale;
            stub_rdata = vecs[i].stub;
            send(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0, 1'b0);
            wait_idle();
            check("cs_high_len", 32'(cs_len_last), 32'(vecs[i].exp_len));
        end
        repeat (4) @(negedge clk);
        check("rdata_hold", 32'(rsp_rdata_o), 32'h0000FFFF);

        // Back-to-back with valid held; responses tagged by address.
        stub_lat = 3; stub_stale = 1'b0; stub_rdata = 16'h0000;
        for (int i = 1; i <= 4; i++) begin
            logic [AW-1:0] a;
            a = AW'(i * 16);
            send(1'b1, a, 16'h0000, a[15:0], 1'b0, (i != 4));
        end
        wait_idle();

        // Reset in ACCESS cycle 3 with a stub that never answers.
        stub_lat = 0;
        send(1'b1, 26'h0000077, 16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst_cs", 32'(ram_cs_o), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst_init_done", 32'(init_done_o), 32'd0);
        q.delete();
        n_accept--;
        reset_i = 1'b0;
        powerup_check();

`ifdef RAM_TIMEOUT_EN
        stub_lat = 0; stub_stale = 1'b0; stub_rdata = 16'h9999;
        send(1'b1, 26'h0000042, 16'h0000, 16'h0000, 1'b1, 1'b0);
        wait_idle();
        check("timeout_len", 32'(cs_len_last), 32'(TMO));
        stub_lat = 3; stub_rdata = 16'h1357;
        send(1'b1, 26'h0000000, 16'h0000, 16'h1357, 1'b0, 1'b0);
        wait_idle();
        check("after_timeout_len", 32'(cs_len_last), 32'd3);
`endif

        repeat (5) @(negedge clk);
        check("rsp_count", 32'(rsp_cnt), 32'(n_accept));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ram_req_sequencer.md
Name: ram_req_sequencer

Overview:
Upstream request sequencer for the asynchronous cellular-RAM interface block. It accepts single-word read/write requests from a client over a valid/ready handshake and enforces a power-up wait before the first access. For each request it drives the RAM interface's chip-select/rnw/address/write-data inputs, holds them stable until the interface reports ready, and then returns a one-cycle response carrying the captured read data. It also inserts a chip-select-low gap between consecutive accesses.

Parameters:
ADDR_W, 26, address width (matches RAM interface)
DATA_W, 16, data width
PWRUP_CYCLES, 16000, clk_i cycles held in INIT after reset (160 us at 100 MHz)
GAP_CYCLES, 1, cycles ram_cs_o is held low between accesses (>=1)
TIMEOUT_CYCLES, 64, ACCESS cycles before abort (RAM_TIMEOUT_EN only)

Ports:
clk_i  in  1  single clock, rising edge
reset_i  in  1  synchronous, active-high reset
req_valid_i  in  1  client request valid
req_ready_o  out  1  sequencer can accept a request
req_rnw_i  in  1  1=read, 0=write
req_addr_i  in  ADDR_W  word address
req_wdata_i  in  DATA_W  write data
rsp_valid_o  out  1  one-cycle completion pulse (reads and writes)
rsp_rdata_o  out  DATA_W  read data; 0 for writes
rsp_err_o  out  1  completion was a timeout abort (0 when feature is compiled out)
init_done_o  out  1  power-up wait finished
ram_cs_o  out  1  to RAM interface cs_i
ram_rnw_o  out  1  to RAM interface rnw_i
ram_addr_o  out  ADDR_W  to RAM interface addr_i
ram_wdata_o  out  DATA_W  to RAM interface wdata_i
ram_rdata_i  in  DATA_W  from RAM interface rdata_o
ram_ready_i  in  1  from RAM interface ready_o (level; may stay high between accesses)

Behaviour:
- One clock domain (clk_i). reset_i is synchronous and active-high. All outputs are registered.
- Reset values: state=INIT, all counters 0, and every output 0. Outputs covered: req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o, ram_cs_o, ram_rnw_o, ram_addr_o, ram_wdata_o.
- Reset asserted mid-access: ram_cs_o=0 on the next edge, no rsp_valid_o pulse, and the block re-enters INIT with the full power-up wait.
- INIT: counter counts to PWRUP_CYCLES, then the block moves to IDLE and sets init_done_o=1 (sticky until reset). With PWRUP_CYCLES=0, INIT lasts exactly one cycle. Counter width is $clog2(PWRUP_CYCLES+1), with a minimum of 1.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, the block latches rnw/addr/wdata into ram_* outputs, sets ram_cs_o=1 and req_ready_o=0 on the same edge, and moves to ACCESS.
- ACCESS:
  - ram_cs_o=1; ram_rnw_o, ram_addr_o and ram_wdata_o are held constant.
  - An access-cycle counter increments every cycle.
  - ram_ready_i is ignored in the first ACCESS cycle (count==0), because it may still be high from the previous access. It is qualified from count>=1.
  - On qualified ram_ready_i: ram_cs_o=0, rsp_valid_o=1 for one cycle, and rsp_rdata_o = ram_rdata_i sampled that cycle for reads, or 0 for writes. The block then moves to GAP.
- GAP: ram_cs_o=0 for GAP_CYCLES cycles, then the block returns to IDLE and req_ready_o=1.
- Minimum request-to-request spacing: 1 (accept) + ACCESS length + GAP_CYCLES.
- rsp_rdata_o holds its last value until the next rsp_valid_o.
- req_valid_i while not in IDLE is ignored (not accepted); the client must hold it.
- req_* inputs are don't-care outside the accept cycle.

Optional Feature:
- Macro: RAM_TIMEOUT_EN.
- Defined: if the ACCESS counter reaches TIMEOUT_CYCLES with no qualified ram_ready_i, the block:
  - drops ram_cs_o;
  - pulses rsp_valid_o=1 with rsp_err_o=1 and rsp_rdata_o=0;
  - enters GAP.
- Defined, simultaneous qualified ready and timeout on the same cycle: the access completes normally, with rsp_err_o=0.
- Not defined: ACCESS waits indefinitely, and rsp_err_o is tied 0. The port exists in both builds.

Test Plan:
- Power-up: PWRUP_CYCLES=20, reset released, req_valid_i=1 held -> init_done_o and req_ready_o rise after 20 cycles; ram_cs_o stays 0 throughout INIT.
- Write: req addr=0x0000123, wdata=0xBEEF, rnw=0; RAM stub raises ready after 8 cs-high cycles -> ram_addr_o/ram_wdata_o stable for all 8 cycles, one rsp_valid_o pulse with rsp_rdata_o=0, ram_cs_o low for GAP_CYCLES before the next accept.
- Read with stale ready: stub leaves ram_ready_i=1 between accesses and returns 0xA5C3 -> ready is not taken in the first ACCESS cycle; rsp_rdata_o=0xA5C3 at the qualified ready; exactly one response per request.
- Back-to-back: 4 requests with req_valid_i held continuously -> exactly 4 accepts and 4 responses in order, each separated by >=GAP_CYCLES of ram_cs_o=0.
- Reset mid-ACCESS: reset_i high for 1 cycle at ACCESS cycle 3 -> ram_cs_o=0 on the next edge, no rsp_valid_o, init_done_o=0, INIT restarts.
- RAM_TIMEOUT_EN, TIMEOUT_CYCLES=64, stub never ready -> ram_cs_o drops after 64 ACCESS cycles; rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0; the next request then completes normally with rsp_err_o=0.
